// File: rtl/muldiv_issue.sv
// Issue/capture control for an external multiply/divide unit, with the HI/LO registers.
// Optional `MULDIV_DIV0_BYPASS_EN: a DIVU by zero is resolved locally (hi=a, lo=all ones) without issuing.
module muldiv_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        md_valid,
    output logic        md_mode,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_ready,
    input  logic [63:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nxt;
    logic   is_md, bypass, accept;

    assign is_md = req_valid && !req_op[1];
`ifdef MULDIV_DIV0_BYPASS_EN
    assign bypass = is_md && req_op[0] && (req_b == 32'd0);
`else
    assign bypass = 1'b0;
`endif
    assign accept = is_md && !bypass;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                    stall     = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                stall     = 1'b1;
            end
            WAIT: begin
                stall = 1'b1;
                if (md_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MFHI/MFLO reads are served directly; a stalled read retries once back in IDLE.
    always_comb begin
        rd_data = 32'd0;
        if (req_valid && req_op[1]) rd_data = req_op[0] ? lo : hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            md_valid <= 1'b0;
            md_mode  <= 1'b0;
            md_a     <= 32'd0;
            md_b     <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            state    <= state_nxt;
            md_valid <= (state == IDLE) && accept;
            if ((state == IDLE) && accept) begin
                md_mode <= req_op[0];
                md_a    <= req_a;
                md_b    <= req_b;
            end
            if ((state == WAIT) && md_ready) begin
                hi <= md_out[63:32];
                lo <= md_out[31:0];
            end
            if ((state == IDLE) && bypass) begin
                hi <= req_a;
                lo <= 32'hFFFF_FFFF;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench for muldiv_issue; the bench emulates the multiply/divide unit itself.
module tb_muldiv_issue;
    logic        clk = 1'b0;
    logic        rst, req_valid, md_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [63:0] md_out;
    logic        stall, md_valid, md_mode;
    logic [31:0] rd_data, md_a, md_b, hi, lo;

    int n_pass = 0, n_total = 0;
    int cyc = 0, pulse_cnt = 0, last_pulse = 0;
    logic [63:0] sb[$];
    logic [31:0] cur_hi = 0, cur_lo = 0;

    muldiv_issue dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .stall(stall), .rd_data(rd_data),
        .md_valid(md_valid), .md_mode(md_mode), .md_a(md_a), .md_b(md_b),
        .md_ready(md_ready), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (md_valid) begin
            pulse_cnt  <= pulse_cnt + 1;
            last_pulse <= cyc;
        end
    end

    // Reference result; a zero divisor returns {dividend, all ones}.
    function automatic logic [63:0] md_model(input logic mode, input logic [31:0] a, input logic [31:0] b);
        if (!mode) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Called at a negedge in IDLE; returns 1ns after the negedge following capture.
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit early_ready, input bit hold_mf);
        logic [63:0] exp;
        int pc0;
        bit hold_ok;
        pc0 = pulse_cnt;
        sb.push_back(md_model(op[0], a, b));
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL accept_stall: got %b want 1", stall); else n_pass++;
        @(negedge clk);
        req_valid = 0; req_op = 2'b00; req_a = $urandom; req_b = $urandom;
        if (early_ready) begin md_ready = 1; md_out = 64'hDEAD_BEEF_0BAD_F00D; end
        #1;
        n_total++;
        if (md_valid !== 1'b1 || md_mode !== op[0] || md_a !== a || md_b !== b || stall !== 1'b1)
            $display("FAIL issue: md_valid=%b mode=%b a=%h b=%h stall=%b want 1 %b %h %h 1",
                     md_valid, md_mode, md_a, md_b, stall, op[0], a, b);
        else n_pass++;
        @(negedge clk);
        md_ready = 0;
        if (hold_mf) begin req_valid = 1; req_op = 2'b10; end
        hold_ok = 1;
        for (int i = 0; i < lat; i++) begin
            #1;
            if (md_valid !== 1'b0 || stall !== 1'b1 || hi !== cur_hi || lo !== cur_lo) hold_ok = 0;
            @(negedge clk);
        end
        n_total++;
        if (!hold_ok) $display("FAIL wait_hold: md_valid/stall/hi/lo disturbed during WAIT");
        else n_pass++;
        md_ready = 1; md_out = md_model(md_mode, md_a, md_b);
        @(negedge clk);
        md_ready = 0; md_out = {$urandom, $urandom};
        #1;
        exp = sb.pop_front();
        cur_hi = exp[63:32]; cur_lo = exp[31:0];
        n_total++;
        if (stall !== 1'b0 || hi !== cur_hi || lo !== cur_lo)
            $display("FAIL capture: stall=%b hi=%h lo=%h want 0 %h %h", stall, hi, lo, cur_hi, cur_lo);
        else n_pass++;
        if (hold_mf) begin
            n_total++;
            if (rd_data !== cur_hi) $display("FAIL mfhi_retry: got %h want %h", rd_data, cur_hi);
            else n_pass++;
            req_valid = 0; req_op = 2'b00;
        end
        n_total++;
        if (pulse_cnt !== pc0 + 1) $display("FAIL md_valid_pulses: got %0d want %0d", pulse_cnt - pc0, 1);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; md_ready = 0; md_out = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        n_total++;
        if (stall !== 0 || md_valid !== 0 || md_mode !== 0 || md_a !== 0 || md_b !== 0 ||
            hi !== 0 || lo !== 0 || rd_data !== 0)
            $display("FAIL reset: stall=%b md_valid=%b mode=%b a=%h b=%h hi=%h lo=%h rd=%h want all 0",
                     stall, md_valid, md_mode, md_a, md_b, hi, lo, rd_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_multu;
        run_md(2'b00, 32'hFFFF_FFFF, 32'h2, 3, 1, 0);
        n_total++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) $display("FAIL multu_max: hi=%h lo=%h want 1 fffffffe", hi, lo);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_divu;
        run_md(2'b01, 32'd100, 32'd7, 2, 0, 0);
        @(negedge clk);
        req_valid = 1; req_op = 2'b11;
        #1;
        n_total++;
        if (rd_data !== 32'd14 || stall !== 0) $display("FAIL mflo_idle: rd=%0d stall=%b want 14 0", rd_data, stall);
        else n_pass++;
        req_op = 2'b10;
        #1;
        n_total++;
        if (rd_data !== 32'd2) $display("FAIL mfhi_idle: rd=%0d want 2", rd_data);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (md_valid !== 0 || stall !== 0 || hi !== 32'd2) $display("FAIL mf_no_state: md_valid=%b stall=%b hi=%h", md_valid, stall, hi);
        else n_pass++;
        req_op = 2'b00; req_valid = 0;
        #1;
        n_total++;
        if (rd_data !== 0) $display("FAIL rd_zero: rd=%h want 0", rd_data);
        else n_pass++;
        req_valid = 1;
        #1;
        n_total++;
        if (rd_data !== 0) $display("FAIL rd_zero_mdop: rd=%h want 0", rd_data);
        else n_pass++;
        req_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_mf_during_wait;
        run_md(2'b01, 32'd1000, 32'd33, 4, 0, 1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int p1, lat;
        lat = 2;
        run_md(2'b00, 32'd3, 32'd5, lat, 0, 0);
        p1 = last_pulse;
        n_total++;
        if (lo !== 32'd15) $display("FAIL b2b_first: lo=%0d want 15", lo); else n_pass++;
        run_md(2'b00, 32'd6, 32'd7, lat, 0, 0);
        n_total++;
        if (lo !== 32'd42 || last_pulse - p1 !== lat + 3)
            $display("FAIL b2b_second: lo=%0d gap=%0d want 42 %0d", lo, last_pulse - p1, lat + 3);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait;
        int pc0;
        req_valid = 1; req_op = 2'b00; req_a = 32'd11; req_b = 32'd13;
        @(negedge clk);
        req_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        cur_hi = 0; cur_lo = 0;
        pc0 = pulse_cnt;
        md_ready = 1; md_out = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        md_ready = 0;
        #1;
        n_total++;
        if (stall !== 0 || hi !== 0 || lo !== 0 || md_valid !== 0 || md_a !== 0 || pulse_cnt !== pc0)
            $display("FAIL reset_mid_wait: stall=%b hi=%h lo=%h md_valid=%b md_a=%h want 0s", stall, hi, lo, md_valid, md_a);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_div0;
`ifdef MULDIV_DIV0_BYPASS_EN
        int pc0;
        pc0 = pulse_cnt;
        req_valid = 1; req_op = 2'b01; req_a = 32'd9; req_b = 32'd0;
        #1;
        n_total++;
        if (stall !== 0) $display("FAIL div0_stall: got %b want 0", stall); else n_pass++;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        #1;
        n_total++;
        if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF || pulse_cnt !== pc0 || stall !== 0)
            $display("FAIL div0_bypass: hi=%h lo=%h pulses=%0d want 9 ffffffff 0", hi, lo, pulse_cnt - pc0);
        else n_pass++;
`else
        run_md(2'b01, 32'd9, 32'd0, 1, 0, 0);
`endif
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_multu;
        test_divu;
        test_mf_during_wait;
        test_back_to_back;
        test_reset_mid_wait;
        test_div0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-002 rst  input  1  Reset; SHALL be synchronous and active-high.
REQ-003 req_valid  input  1  Pipeline request strobe, sampled only in IDLE.
REQ-004 req_op  input  2  Operation: 00 MULTU, 01 DIVU, 10 MFHI, 11 MFLO.
REQ-005 req_a  input  32  Operand A (multiplicand / dividend).
REQ-006 req_b  input  32  Operand B (multiplier / divisor).
REQ-007 stall  output  1  Pipeline hold, combinational.
REQ-008 rd_data  output  32  MFHI/MFLO read data, combinational.
REQ-009 md_valid  output  1  Start strobe to the multiply/divide unit, registered.
REQ-010 md_mode  output  1  0 multu, 1 divu, registered; held from issue until capture.
REQ-011 md_a, md_b  output  32 each  Latched operands, registered; held from issue until capture.
REQ-012 md_ready  input  1  Result-valid pulse from the multiply/divide unit.
REQ-013 md_out  input  64  Result: [63:32] product-high/remainder, [31:0] product-low/quotient.
REQ-014 hi, lo  output  32 each  Architectural HI/LO registers.

Function
REQ-015 FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-016 IDLE: on req_valid with op 00/01, the block SHALL latch req_a, req_b and mode (op[0]) and enter ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 ISSUE SHALL last exactly one cycle with md_valid=1, then enter WAIT; md_valid SHALL be 0 in every other state.
REQ-018 WAIT: when md_ready=1, the block SHALL write hi<=md_out[63:32] and lo<=md_out[31:0], then enter IDLE; otherwise it SHALL stay in WAIT with no timeout.
REQ-019 md_ready SHALL be ignored in IDLE and ISSUE; hi/lo SHALL change only on a WAIT capture, a bypass (REQ-027), or reset.
REQ-020 stall SHALL be 1 when state!=IDLE, or when state==IDLE with req_valid=1 and op 00/01; it SHALL be 0 otherwise.
REQ-021 Timing: stall SHALL fall in the cycle after the md_ready capture, and hi/lo SHALL be visible in that same cycle.
REQ-022 MFHI/MFLO in IDLE: rd_data SHALL equal hi/lo with no stall and no state change.
REQ-023 MFHI/MFLO while not IDLE: stall SHALL be 1; the pipeline holds the request and it completes on return to IDLE.
REQ-024 rd_data SHALL be 0 when req_op is 00/01 or req_valid=0.
REQ-025 A back-to-back request presented in the cycle stall falls SHALL be accepted immediately as a new IDLE request.

Reset
REQ-026 On rst=1, regardless of state (including mid-WAIT), the block SHALL set state=IDLE, md_valid=0, md_mode=0, md_a=md_b=0 and hi=lo=0. After reset it SHALL ignore stale md_ready until the next issue; rst SHALL be tied to the multiply/divide unit's reset.

Configuration
REQ-027 Macro MULDIV_DIV0_BYPASS_EN, when defined:
- A DIVU with req_b==0 SHALL NOT issue.
- The block SHALL stay in IDLE and write hi<=req_a and lo<=32'hFFFFFFFF at the next edge.
- stall SHALL be 0 for that request.
REQ-028 Without MULDIV_DIV0_BYPASS_EN, divide-by-zero SHALL issue normally and capture whatever md_out returns.

Verification
REQ-029 MULTU a=32'hFFFFFFFF, b=32'h2 -> single md_valid pulse, stall held through WAIT; after md_ready, hi=32'h1, lo=32'hFFFFFFFE, stall low the next cycle.
REQ-030 DIVU a=100, b=7 -> md_mode=1; after capture, hi=2, lo=14; then MFLO in IDLE -> rd_data=14 with stall=0.
REQ-031 MFHI issued during WAIT -> stall=1 until capture; rd_data returns the new hi in the first IDLE cycle.
REQ-032 rst pulsed mid-WAIT, then a spurious md_ready -> state IDLE, hi=lo=0, no capture.
REQ-033 Back-to-back MULTU 3x5 then MULTU 6x7 -> two md_valid pulses separated by the full WAIT period; lo=15, then lo=42.
REQ-034 DIVU a=9, b=0 with MULDIV_DIV0_BYPASS_EN -> no md_valid, stall=0, hi=9, lo=32'hFFFFFFFF; without the macro -> normal issue.
